rep_string_ctrl: RTL and testbench



---
 rtl/rep_string_ctrl_pkg.sv | 18 +
 rtl/rep_step_gen.sv | 33 +++
 rtl/rep_string_ctrl.sv | 146 ++++++++++++++
 tb/tb_rep_string_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rep_string_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rep_string_ctrl_pkg
// Description : Shared encodings for the REP string-instruction sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package rep_string_ctrl_pkg;

    localparam logic [1:0] OPSZ_8  = 2'd0;
    localparam logic [1:0] OPSZ_16 = 2'd1;
    localparam logic [1:0] OPSZ_32 = 2'd2;
    localparam logic [1:0] OPSZ_64 = 2'd3;

    localparam logic [0:0] REP_IDLE = 1'b0;
    localparam logic [0:0] REP_RUN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rep_step_gen.sv
`default_nettype none
// ============================================================================
// Module      : rep_step_gen
// Description : Converts operand size and direction flag into a signed
//               per-iteration address step (two's complement when decrementing).
// Revision    : 1.0  initial release
// ============================================================================
module rep_step_gen
    import rep_string_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [1:0]            opsize,
    input  logic                  dflag,
    output logic [ADDR_WIDTH-1:0] step
);

    logic [ADDR_WIDTH-1:0] w_mag;

    always_comb begin
        w_mag = '0;
        case (opsize)
            OPSZ_8:  w_mag[0] = 1'b1;
            OPSZ_16: w_mag[1] = 1'b1;
            OPSZ_32: w_mag[2] = 1'b1;
            OPSZ_64: w_mag[3] = 1'b1;
            default: w_mag[0] = 1'b1;
        endcase
        step = dflag ? -w_mag : w_mag;
    end

endmodule
`default_nettype wire

// File: rtl/rep_string_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rep_string_ctrl
// Description : Issues one REP string iteration per cycle, stepping both
//               memory addresses and decrementing the count; non-REP passes.
// Revision    : 1.0  initial release
// ============================================================================
module rep_string_ctrl
    import rep_string_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  valid,
    input  logic                  is_rep,
    input  logic                  no_other_stall,
    input  logic                  flush,
    input  logic [CNT_WIDTH-1:0]  count_in,
    input  logic [1:0]            opsize,
    input  logic                  dflag,
    input  logic                  step1_en,
    input  logic                  step2_en,
    input  logic [ADDR_WIDTH-1:0] mem1_in,
    input  logic [ADDR_WIDTH-1:0] mem2_in,
    output logic [ADDR_WIDTH-1:0] mem_addr1,
    output logic [ADDR_WIDTH-1:0] mem_addr2,
    output logic                  iter_valid,
    output logic                  last_iter,
    output logic [CNT_WIDTH-1:0]  cnt_out,
    output logic                  zero_skip,
    output logic                  rep_stall
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr1;
    logic [ADDR_WIDTH-1:0] r_addr2;
    logic [ADDR_WIDTH-1:0] r_step1;
    logic [ADDR_WIDTH-1:0] r_step2;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_step1;
    logic [ADDR_WIDTH-1:0] w_step2;
    logic                  w_accept;
    logic                  w_start;
    logic                  w_running;
    logic                  w_in_one;
    logic                  w_run_last;

    rep_step_gen #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_step_gen (
        .opsize (opsize),
        .dflag  (dflag),
        .step   (w_step)
    );

    assign w_step1    = step1_en ? w_step : '0;
    assign w_step2    = step2_en ? w_step : '0;
    assign w_accept   = (r_state == REP_IDLE) & valid & no_other_stall & ~flush;
    assign w_in_one   = (count_in == c_cnt_one);
    assign w_start    = w_accept & is_rep & (count_in > c_cnt_one);
    assign w_running  = (r_state == REP_RUN) & ~flush;
    assign w_run_last = (r_cnt == c_cnt_one);

    always_comb begin
        mem_addr1  = '0;
        mem_addr2  = '0;
        iter_valid = 1'b0;
        last_iter  = 1'b0;
        cnt_out    = '0;
        zero_skip  = 1'b0;
        rep_stall  = 1'b0;
        if (!clr) begin
            if (w_accept) begin
                if (!is_rep) begin
                    iter_valid = 1'b1;
                    last_iter  = 1'b1;
                    mem_addr1  = mem1_in;
                    mem_addr2  = mem2_in;
                    cnt_out    = count_in;
                end else if (count_in == '0) begin
                    zero_skip  = 1'b1;
                end else begin
                    iter_valid = 1'b1;
                    last_iter  = w_in_one;
                    rep_stall  = ~w_in_one;
                    mem_addr1  = mem1_in;
                    mem_addr2  = mem2_in;
                    cnt_out    = count_in - c_cnt_one;
                end
            end else if (w_running) begin
                // Final iteration releases the latch in the same cycle it issues
                iter_valid = no_other_stall;
                last_iter  = w_run_last;
                rep_stall  = ~w_run_last;
                mem_addr1  = r_addr1;
                mem_addr2  = r_addr2;
                cnt_out    = r_cnt - c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= REP_IDLE;
            r_addr1 <= '0;
            r_addr2 <= '0;
            r_step1 <= '0;
            r_step2 <= '0;
            r_cnt   <= '0;
        end else if (flush) begin
            r_state <= REP_IDLE;
        end else begin
            case (r_state)
                REP_IDLE: begin
                    if (w_start) begin
                        r_addr1 <= mem1_in + w_step1;
                        r_addr2 <= mem2_in + w_step2;
                        r_step1 <= w_step1;
                        r_step2 <= w_step2;
                        r_cnt   <= count_in - c_cnt_one;
                        r_state <= REP_RUN;
                    end
                end
                REP_RUN: begin
                    if (no_other_stall) begin
                        r_addr1 <= r_addr1 + r_step1;
                        r_addr2 <= r_addr2 + r_step2;
                        r_cnt   <= r_cnt - c_cnt_one;
                        if (w_run_last) begin
                            r_state <= REP_IDLE;
                        end
                    end
                end
                default: r_state <= REP_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rep_string_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rep_string_ctrl
// Description : Randomized scoreboard bench for rep_string_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
module tb_rep_string_ctrl;

    logic        clk = 1'b0;
    logic        clr, valid, is_rep, no_other_stall, flush, dflag, step1_en, step2_en;
    logic [31:0] count_in, mem1_in, mem2_in;
    logic [1:0]  opsize;
    logic [31:0] mem_addr1, mem_addr2, cnt_out;
    logic        iter_valid, last_iter, zero_skip, rep_stall;

    typedef struct {
        logic        zs;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] cnt;
        logic        last;
        logic        stall;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic post_clr = 1'b0;
    logic mon_en   = 1'b0;

    rep_string_ctrl #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk(clk), .clr(clr), .valid(valid), .is_rep(is_rep),
        .no_other_stall(no_other_stall), .flush(flush), .count_in(count_in),
        .opsize(opsize), .dflag(dflag), .step1_en(step1_en), .step2_en(step2_en),
        .mem1_in(mem1_in), .mem2_in(mem2_in), .mem_addr1(mem_addr1),
        .mem_addr2(mem_addr2), .iter_valid(iter_valid), .last_iter(last_iter),
        .cnt_out(cnt_out), .zero_skip(zero_skip), .rep_stall(rep_stall)
    );

    initial forever #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (clr || post_clr) begin
                chk1("outputs_zero_clr", (|mem_addr1) | (|mem_addr2) | (|cnt_out) |
                     iter_valid | last_iter | zero_skip | rep_stall, 1'b0);
            end else begin
                if (flush) chk1("flush_quiet", iter_valid | rep_stall, 1'b0);
                if (!no_other_stall) chk1("stall_no_issue", iter_valid, 1'b0);
                if (iter_valid || zero_skip) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_output: got iter_valid=%0b zero_skip=%0b expected none at %0t",
                                 iter_valid, zero_skip, $time);
                    end else begin
                        e = sb.pop_front();
                        if (e.zs) begin
                            chk1("zs_zero_skip", zero_skip, 1'b1);
                            chk1("zs_iter_valid", iter_valid, 1'b0);
                            chk1("zs_rep_stall", rep_stall, 1'b0);
                            chk32("zs_cnt_out", cnt_out, 32'd0);
                        end else begin
                            chk1("iter_valid", iter_valid, 1'b1);
                            chk1("zero_skip", zero_skip, 1'b0);
                            chk32("mem_addr1", mem_addr1, e.a1);
                            chk32("mem_addr2", mem_addr2, e.a2);
                            chk32("cnt_out", cnt_out, e.cnt);
                            chk1("last_iter", last_iter, e.last);
                            chk1("rep_stall", rep_stall, e.stall);
                        end
                    end
                end
            end
        end
    end

    task automatic drive_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        count_in = $urandom;
        mem1_in  = $urandom;
        mem2_in  = $urandom;
        opsize   = 2'($urandom_range(0, 3));
        dflag    = 1'($urandom_range(0, 1));
        step1_en = 1'($urandom_range(0, 1));
        step2_en = 1'($urandom_range(0, 1));
    endtask

    // Reference: iteration i sits at base + i*step and leaves count N-1-i
    task automatic run_instr(input logic rep, input logic [31:0] cnt, input logic [1:0] osz,
                             input logic df, input logic s1, input logic s2,
                             input logic [31:0] m1, input logic [31:0] m2,
                             input int abort_at, input int abort_clr, input int stall_pct,
                             input int fstall_at, input int fstall_len);
        int          needed;
        int          issued;
        int          left;
        logic [31:0] mag, st1, st2;
        exp_t        e;
        mag = 32'd1 << osz;
        st1 = s1 ? (df ? -mag : mag) : 32'd0;
        st2 = s2 ? (df ? -mag : mag) : 32'd0;
        if (!rep) begin
            e.zs = 1'b0; e.a1 = m1; e.a2 = m2; e.cnt = cnt; e.last = 1'b1; e.stall = 1'b0;
            sb.push_back(e);
            needed = 1;
        end else if (cnt == 32'd0) begin
            e.zs = 1'b1; e.a1 = '0; e.a2 = '0; e.cnt = '0; e.last = 1'b0; e.stall = 1'b0;
            sb.push_back(e);
            needed = 1;
        end else begin
            needed = int'(cnt);
            for (int i = 0; i < needed; i++) begin
                if (abort_at < 0 || i < abort_at) begin
                    e.zs    = 1'b0;
                    e.a1    = m1 + 32'(i) * st1;
                    e.a2    = m2 + 32'(i) * st2;
                    e.cnt   = cnt - 32'd1 - 32'(i);
                    e.last  = (i == needed - 1);
                    e.stall = (i != needed - 1);
                    sb.push_back(e);
                end
            end
        end
        valid = 1'b1; is_rep = rep; count_in = cnt; opsize = osz; dflag = df;
        step1_en = s1; step2_en = s2; mem1_in = m1; mem2_in = m2;
        issued = 0;
        left   = fstall_len;
        while (issued < needed && !(abort_at >= 0 && issued == abort_at)) begin
            if (issued == fstall_at && left > 0) begin
                no_other_stall = 1'b0;
                left--;
            end else begin
                no_other_stall = ($urandom_range(0, 99) >= stall_pct);
            end
            drive_cycle();
            if (no_other_stall) begin
                issued++;
                if (rep) scramble();
            end
        end
        if (abort_at >= 0 && issued == abort_at) begin
            valid = 1'b0;
            no_other_stall = 1'($urandom_range(0, 1));
            if (abort_clr != 0) clr = 1'b1;
            else flush = 1'b1;
            drive_cycle();
            flush = 1'b0;
            clr   = 1'b0;
            post_clr = (abort_clr != 0);
            drive_cycle();
            post_clr = 1'b0;
        end
        chk32("sb_drained", 32'(sb.size()), 32'd0);
        valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            no_other_stall = 1'($urandom_range(0, 1));
            scramble();
            drive_cycle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clr = 1'b1; valid = 1'b0; is_rep = 1'b0; no_other_stall = 1'b1; flush = 1'b0;
        count_in = '0; opsize = '0; dflag = 1'b0; step1_en = 1'b0; step2_en = 1'b0;
        mem1_in = '0; mem2_in = '0;
        #1;
        mon_en = 1'b1;
        repeat (3) drive_cycle();
        clr = 1'b0;
        drive_cycle();

        run_instr(1'b0, 32'd7, 2'd2, 1'b0, 1'b1, 1'b1, 32'h1000, 32'h2000, -1, 0, 0, -1, 0);
        run_instr(1'b1, 32'd3, 2'd2, 1'b0, 1'b1, 1'b1, 32'h1000, 32'h2000, -1, 0, 0, -1, 0);
        run_instr(1'b1, 32'd0, 2'd1, 1'b0, 1'b1, 1'b1, 32'h3000, 32'h4000, -1, 0, 0, -1, 0);
        run_instr(1'b1, 32'd1, 2'd3, 1'b1, 1'b1, 1'b1, 32'h3000, 32'h4000, -1, 0, 0, -1, 0);
        run_instr(1'b1, 32'd2, 2'd0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h50, -1, 0, 0, -1, 0);
        run_instr(1'b1, 32'd4, 2'd1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h200, -1, 0, 0, 1, 2);
        run_instr(1'b1, 32'd5, 2'd2, 1'b0, 1'b1, 1'b1, 32'h500, 32'h600, 2, 0, 0, -1, 0);
        run_instr(1'b1, 32'd5, 2'd2, 1'b0, 1'b1, 1'b1, 32'h500, 32'h600, 2, 1, 0, -1, 0);

        for (int n = 0; n < 60; n++) begin
            logic        rep;
            logic [31:0] cnt;
            int          ab;
            int          abc;
            rep = ($urandom_range(0, 3) != 0);
            cnt = rep ? 32'($urandom_range(0, 6)) : $urandom;
            ab  = -1;
            abc = 0;
            if (rep && cnt >= 32'd2 && $urandom_range(0, 4) == 0) begin
                ab  = int'($urandom_range(1, int'(cnt) - 1));
                abc = int'($urandom_range(0, 1));
            end
            run_instr(rep, cnt, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom, ab, abc, 25, -1, 0);
        end

        chk32("sb_final_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
